// File: rtl/axi_rd_arb_pkg.sv
// Shared types and constants for the AXI read-channel arbiter and its users.
package axi_rd_arb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int AR_ADDR_W = 64;
  localparam int AR_ID_W   = 8;

  // Index width for a channel count; a single channel still needs one bit.
  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  typedef struct packed {
    logic [AR_ADDR_W-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
    logic [AR_ID_W-1:0]   id;
  } ar_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr.
// Pointer moves past the winner only when advance_i is high.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (advance_i && any_o)
      rr_ptr_d = (gnt_idx_o == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx_o + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// N-to-1 AXI read arbiter: round-robin registered AR with channel-tagged ARID, RID-routed R.
// Define AXI_RD_ARB_RSLICE_EN to insert a two-entry skid buffer on the R path.
module axi_rd_arbiter
  import axi_rd_arb_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int ADDR_W    = 64,
  parameter  int DATA_W    = 512,
  parameter  int ID_W      = 4,
  parameter  int MAX_OUTST = 16,
  localparam int CH_W      = ch_width(NUM_CH),
  localparam int M_ID_W    = ID_W + CH_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        s_arvalid,
  output logic [NUM_CH-1:0]        s_arready,
  input  logic [NUM_CH*ADDR_W-1:0] s_araddr,
  input  logic [NUM_CH*8-1:0]      s_arlen,
  input  logic [NUM_CH*3-1:0]      s_arsize,
  input  logic [NUM_CH*2-1:0]      s_arburst,
  input  logic [NUM_CH*ID_W-1:0]   s_arid,
  output logic [NUM_CH-1:0]        s_rvalid,
  input  logic [NUM_CH-1:0]        s_rready,
  output logic [DATA_W-1:0]        s_rdata,
  output logic [1:0]               s_rresp,
  output logic [ID_W-1:0]          s_rid,
  output logic                     s_rlast,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [ADDR_W-1:0]        m_araddr,
  output logic [7:0]               m_arlen,
  output logic [2:0]               m_arsize,
  output logic [1:0]               m_arburst,
  output logic [M_ID_W-1:0]        m_arid,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic                     m_rlast,
  input  logic [M_ID_W-1:0]        m_rid,
  output logic                     err_rid
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  logic [NUM_CH-1:0] elig, gnt, ar_hs, r_dec;
  logic [CH_W-1:0]   gnt_idx;
  logic              any_elig, load;
  logic [OW-1:0]     outst_q [NUM_CH];
  logic [OW-1:0]     outst_d [NUM_CH];

  logic              m_arvalid_q;
  logic [ADDR_W-1:0] m_araddr_q;
  logic [7:0]        m_arlen_q;
  logic [2:0]        m_arsize_q;
  logic [1:0]        m_arburst_q;
  logic [M_ID_W-1:0] m_arid_q;
  logic              err_rid_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      elig[i] = s_arvalid[i] && (outst_q[i] < OW'(MAX_OUTST));
  end

  assign load = !m_arvalid_q || m_arready;

  rr_arbiter #(.NUM_REQ(NUM_CH)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_i     (elig),
    .advance_i (load),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (any_elig)
  );

  assign s_arready = gnt & {NUM_CH{load}};
  assign ar_hs     = s_arvalid & s_arready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       m_arvalid_q <= 1'b0;
    else if (load) m_arvalid_q <= any_elig;
  end

  // Payload needs no reset: it is only observed while m_arvalid is high.
  always_ff @(posedge clk) begin
    if (load && any_elig) begin
      m_araddr_q  <= s_araddr[int'(gnt_idx)*ADDR_W +: ADDR_W];
      m_arlen_q   <= s_arlen[int'(gnt_idx)*8 +: 8];
      m_arsize_q  <= s_arsize[int'(gnt_idx)*3 +: 3];
      m_arburst_q <= s_arburst[int'(gnt_idx)*2 +: 2];
      m_arid_q    <= {gnt_idx, s_arid[int'(gnt_idx)*ID_W +: ID_W]};
    end
  end

  assign m_arvalid = m_arvalid_q;
  assign m_araddr  = m_araddr_q;
  assign m_arlen   = m_arlen_q;
  assign m_arsize  = m_arsize_q;
  assign m_arburst = m_arburst_q;
  assign m_arid    = m_arid_q;

  logic              r_vld, r_rdy, r_last, r_hit;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;
  logic [M_ID_W-1:0] r_id;
  logic [CH_W-1:0]   r_ch;

`ifdef AXI_RD_ARB_RSLICE_EN
  localparam int RW = DATA_W + 2 + 1 + M_ID_W;

  logic [RW-1:0] skid_q [2];
  logic          wr_ptr_q, rd_ptr_q, m_rready_q, push, pop;
  logic [1:0]    cnt_q, cnt_d;

  assign push  = m_rvalid && m_rready_q;
  assign pop   = r_vld && r_rdy;
  assign r_vld = (cnt_q != 2'd0);
  assign {r_data, r_resp, r_last, r_id} = skid_q[rd_ptr_q];
  assign cnt_d = cnt_q + 2'(push) - 2'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      m_rready_q <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q      <= cnt_d;
      m_rready_q <= (cnt_d != 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (push) skid_q[wr_ptr_q] <= {m_rdata, m_rresp, m_rlast, m_rid};
  end

  assign m_rready = m_rready_q;
`else
  assign r_vld    = m_rvalid;
  assign r_data   = m_rdata;
  assign r_resp   = m_rresp;
  assign r_last   = m_rlast;
  assign r_id     = m_rid;
  assign m_rready = r_rdy;
`endif

  assign r_ch = r_id[M_ID_W-1 -: CH_W];

  // A beat whose channel index matches no port is accepted and discarded.
  always_comb begin
    s_rvalid = '0;
    r_dec    = '0;
    r_rdy    = 1'b1;
    r_hit    = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch == CH_W'(i)) begin
        r_hit       = 1'b1;
        s_rvalid[i] = r_vld;
        r_rdy       = s_rready[i];
        r_dec[i]    = r_vld && s_rready[i] && r_last;
      end
    end
  end

  assign s_rdata = r_data;
  assign s_rresp = r_resp;
  assign s_rlast = r_last;
  assign s_rid   = r_id[ID_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err_rid_q <= 1'b0;
    else if (r_vld && !r_hit) err_rid_q <= 1'b1;
  end
  assign err_rid = err_rid_q;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      outst_d[i] = outst_q[i];
      case ({ar_hs[i], r_dec[i]})
        2'b10:   outst_d[i] = outst_q[i] + 1'b1;
        2'b01:   if (outst_q[i] != '0) outst_d[i] = outst_q[i] - 1'b1;
        default: outst_d[i] = outst_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) outst_q[i] <= '0;
    end else begin
      outst_q <= outst_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: a 4-channel instance with two-burst limit and a 3-channel one.
module tb_axi_rd_arbiter;
  import axi_rd_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: NUM_CH=4, DATA_W=64, MAX_OUTST=2
  logic        rst;
  logic [3:0]  s_arvalid, s_arready, s_rvalid, s_rready;
  logic [255:0] s_araddr;
  logic [31:0] s_arlen;
  logic [11:0] s_arsize;
  logic [7:0]  s_arburst;
  logic [15:0] s_arid;
  logic [63:0] s_rdata, m_araddr, m_rdata;
  logic [1:0]  s_rresp, m_arburst, m_rresp;
  logic [3:0]  s_rid;
  logic        s_rlast, m_arvalid, m_arready, m_rvalid, m_rready, m_rlast, err_rid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [5:0]  m_arid, m_rid;

  axi_rd_arbiter #(.NUM_CH(4), .ADDR_W(64), .DATA_W(64), .ID_W(4), .MAX_OUTST(2)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rid(s_rid), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid), .err_rid(err_rid)
  );

  // Second instance: NUM_CH=3, so channel index 3 is out of range
  logic        b_rst, b_m_arready, b_m_rvalid, b_m_rlast;
  logic [2:0]  b_s_arvalid, b_s_arready, b_s_rvalid;
  logic [63:0] b_s_rdata, b_m_araddr;
  logic [1:0]  b_s_rresp, b_m_arburst;
  logic [3:0]  b_s_rid;
  logic        b_s_rlast, b_m_arvalid, b_m_rready, b_err_rid;
  logic [7:0]  b_m_arlen;
  logic [2:0]  b_m_arsize;
  logic [5:0]  b_m_arid, b_m_rid;

  axi_rd_arbiter #(.NUM_CH(3), .ADDR_W(64), .DATA_W(64), .ID_W(4), .MAX_OUTST(2)) dut_b (
    .clk(clk), .rst(b_rst),
    .s_arvalid(b_s_arvalid), .s_arready(b_s_arready), .s_araddr(192'h0), .s_arlen(24'h0),
    .s_arsize(9'h0), .s_arburst(6'h0), .s_arid(12'h0),
    .s_rvalid(b_s_rvalid), .s_rready(3'b111), .s_rdata(b_s_rdata), .s_rresp(b_s_rresp),
    .s_rid(b_s_rid), .s_rlast(b_s_rlast),
    .m_arvalid(b_m_arvalid), .m_arready(b_m_arready), .m_araddr(b_m_araddr), .m_arlen(b_m_arlen),
    .m_arsize(b_m_arsize), .m_arburst(b_m_arburst), .m_arid(b_m_arid),
    .m_rvalid(b_m_rvalid), .m_rready(b_m_rready), .m_rdata(64'h0), .m_rresp(RESP_OKAY),
    .m_rlast(b_m_rlast), .m_rid(b_m_rid), .err_rid(b_err_rid)
  );

  typedef struct packed { logic [5:0] id; logic [63:0] addr; logic [7:0] len; } ar_exp_t;
  typedef struct packed { logic [1:0] ch; logic [3:0] id; logic [1:0] resp; logic [63:0] data; logic last; } r_exp_t;

  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  ar_exp_t ae;
  r_exp_t  re;
  logic [1:0] och;
  logic    exp_rdy;
  bit      ar_sb_en = 1'b0;
  int      ar_hs_total = 0;
  int      ar_last_cyc = 0;
  int      stall_cnt = 0;
  int      s_hs_cnt [4] = '{0, 0, 0, 0};

  // Downstream-side monitor: AR and R scoreboards plus R backpressure routing
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        if (s_arvalid[i] && s_arready[i]) s_hs_cnt[i] = s_hs_cnt[i] + 1;
      if (m_arvalid && m_arready) begin
        ar_hs_total = ar_hs_total + 1;
        ar_last_cyc = cyc;
        if (ar_sb_en) begin
          checks = checks + 1;
          if (ar_q.size() == 0) begin
            failures = failures + 1;
            $display("FAIL ar_unexpected: got arid=%h araddr=%h, required no AR", m_arid, m_araddr);
          end else begin
            ae = ar_q.pop_front();
            if ({m_arid, m_araddr, m_arlen} !== ae) begin
              failures = failures + 1;
              $display("FAIL ar_payload: got id=%h addr=%h len=%0d, required id=%h addr=%h len=%0d",
                       m_arid, m_araddr, m_arlen, ae.id, ae.addr, ae.len);
            end
          end
        end
      end
      if (m_rvalid) begin
        och = m_rid[5:4];
        exp_rdy = s_rready[och];
        checks = checks + 1;
        if (m_rready !== exp_rdy) begin
          failures = failures + 1;
          $display("FAIL r_ready_route: got m_rready=%b, required %b (ch %0d)", m_rready, exp_rdy, och);
        end
        if (!m_rready) stall_cnt = stall_cnt + 1;
      end
      if (|(s_rvalid & s_rready)) begin
        och = 2'd0;
        for (int i = 0; i < 4; i++) if (s_rvalid[i]) och = 2'(i);
        checks = checks + 1;
        if (r_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL r_unexpected: got s_rvalid=%b rid=%h, required no beat", s_rvalid, s_rid);
        end else begin
          re = r_q.pop_front();
          if (!$onehot(s_rvalid) || {och, s_rid, s_rresp, s_rdata, s_rlast} !== re) begin
            failures = failures + 1;
            $display("FAIL r_beat: got rvalid=%b rid=%h resp=%b data=%h last=%b, required ch=%0d rid=%h resp=%b data=%h last=%b",
                     s_rvalid, s_rid, s_rresp, s_rdata, s_rlast, re.ch, re.id, re.resp, re.data, re.last);
          end
        end
      end
    end
  end

  task automatic reset_a();
    rst = 1'b1; s_arvalid = '0; s_rready = '1; m_arready = 1'b1;
    m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = RESP_OKAY; m_rlast = 1'b0;
    s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arid = '0;
    ar_sb_en = 1'b0; ar_q.delete(); r_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_ar(input int ch, input logic [63:0] a, input logic [7:0] l, input logic [3:0] id);
    s_araddr[ch*64 +: 64] = a;
    s_arlen[ch*8 +: 8]    = l;
    s_arsize[ch*3 +: 3]   = 3'd3;
    s_arburst[ch*2 +: 2]  = 2'b01;
    s_arid[ch*4 +: 4]     = id;
  endtask

  task automatic send_beat(input logic [1:0] ch, input logic [3:0] id, input logic [1:0] resp,
                           input logic [63:0] d, input logic last);
    bit done;
    done = 1'b0;
    m_rvalid = 1'b1; m_rid = {ch, id}; m_rresp = resp; m_rdata = d; m_rlast = last;
    r_q.push_back({ch, id, resp, d, last});
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = (m_rready === 1'b1);
      @(posedge clk);
      #1;
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    checks = checks + 1;
    if (!done) begin
      failures = failures + 1;
      $display("FAIL r_timeout: beat ch=%0d id=%h never accepted, required acceptance in 20 cycles", ch, id);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_arvalid = '0; s_rready = '1; m_arready = 1'b0; m_rvalid = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = RESP_OKAY; m_rlast = 1'b0;
    #1;
    checks = checks + 1;
    if (m_arvalid !== 1'b0 || s_arready !== 4'b0 || err_rid !== 1'b0 || s_rvalid !== 4'b0) begin
      failures = failures + 1;
      $display("FAIL reset_state: got arvalid=%b arready=%b err=%b rvalid=%b, required all 0",
               m_arvalid, s_arready, err_rid, s_rvalid);
    end
    reset_a();
  endtask

  task automatic test_single();
    reset_a();
    ar_sb_en = 1'b1;
    set_ar(2, 64'h1000, 8'd3, 4'd5);
    ar_q.push_back({6'h25, 64'h1000, 8'd3});
    s_arvalid = 4'b0100;
    @(negedge clk);
    checks = checks + 1;
    if (s_arready !== 4'b0100) begin
      failures = failures + 1;
      $display("FAIL single_arready: got %b, required 0100", s_arready);
    end
    @(posedge clk); #1 s_arvalid = '0;
    @(negedge clk);
    checks = checks + 1;
    if (m_arvalid !== 1'b1 || m_arid !== 6'h25 || m_arsize !== 3'd3 || m_arburst !== 2'b01) begin
      failures = failures + 1;
      $display("FAIL single_ar: got valid=%b id=%h size=%0d burst=%b, required 1 25 3 01",
               m_arvalid, m_arid, m_arsize, m_arburst);
    end
    checks = checks + 1;
    if (dut.outst_q[2] !== 2'd1) begin
      failures = failures + 1;
      $display("FAIL single_outst_inc: got %0d, required 1", dut.outst_q[2]);
    end
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++)
      send_beat(2'd2, 4'd5, (b == 2) ? RESP_SLVERR : RESP_OKAY, 64'hA000 + 64'(b), b == 3);
    @(negedge clk);
    checks = checks + 1;
    if (dut.outst_q[2] !== 2'd0 || r_q.size() != 0 || ar_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL single_drain: got outst=%0d rq=%0d arq=%0d, required 0 0 0",
               dut.outst_q[2], r_q.size(), ar_q.size());
    end
  endtask

  task automatic test_rr_outst();
    int base [4];
    int hs0, c0;
    reset_a();
    ar_sb_en = 1'b1;
    for (int i = 0; i < 4; i++) set_ar(i, 64'h2000 + 64'(i * 'h40), 8'd0, 4'(i));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        ar_q.push_back({2'(i), 4'(i), 64'h2000 + 64'(i * 'h40), 8'd0});
    for (int i = 0; i < 4; i++) base[i] = s_hs_cnt[i];
    hs0 = ar_hs_total;
    c0  = cyc;
    s_arvalid = 4'b1111;
    repeat (12) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks = checks + 1;
      if (s_hs_cnt[i] - base[i] != 2) begin
        failures = failures + 1;
        $display("FAIL outst_limit ch%0d: got %0d handshakes, required 2", i, s_hs_cnt[i] - base[i]);
      end
    end
    checks = checks + 1;
    if (s_arready !== 4'b0 || ar_q.size() != 0 || ar_hs_total - hs0 != 8 || ar_last_cyc - c0 != 8) begin
      failures = failures + 1;
      $display("FAIL rr_b2b: got arready=%b arq=%0d ars=%0d span=%0d, required 0 0 8 8",
               s_arready, ar_q.size(), ar_hs_total - hs0, ar_last_cyc - c0);
    end
    for (int i = 0; i < 4; i++) base[i] = s_hs_cnt[i];
    ar_q.push_back({6'h00, 64'h2000, 8'd0});
    @(posedge clk); #1;
    send_beat(2'd0, 4'd0, RESP_OKAY, 64'hBEEF, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (s_hs_cnt[0] - base[0] != 1 || s_hs_cnt[1] != base[1] || s_hs_cnt[3] != base[3] ||
        ar_q.size() != 0 || r_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL outst_release: got ch0=%0d ch1=%0d ch3=%0d arq=%0d rq=%0d, required 1 0 0 0 0",
               s_hs_cnt[0] - base[0], s_hs_cnt[1] - base[1], s_hs_cnt[3] - base[3], ar_q.size(), r_q.size());
    end
    s_arvalid = '0;
  endtask

  task automatic test_hold();
    reset_a();
    ar_sb_en = 1'b1;
    m_arready = 1'b0;
    set_ar(1, 64'hABCD_0000, 8'd7, 4'd7);
    ar_q.push_back({6'h17, 64'hABCD_0000, 8'd7});
    s_arvalid = 4'b0010;
    @(posedge clk); #1;
    s_arvalid = 4'b0100;
    set_ar(2, 64'h5555_0000, 8'd1, 4'd3);
    set_ar(1, 64'hDEAD_0000, 8'd2, 4'd9);
    ar_q.push_back({6'h23, 64'h5555_0000, 8'd1});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks = checks + 1;
      if (m_arvalid !== 1'b1 || m_araddr !== 64'hABCD_0000 || m_arid !== 6'h17 || s_arready !== 4'b0) begin
        failures = failures + 1;
        $display("FAIL ar_hold cyc%0d: got valid=%b addr=%h id=%h arready=%b, required 1 abcd0000 17 0000",
                 k, m_arvalid, m_araddr, m_arid, s_arready);
      end
      @(posedge clk); #1;
    end
    m_arready = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (s_arready !== 4'b0100) begin
      failures = failures + 1;
      $display("FAIL ar_release: got arready=%b, required 0100", s_arready);
    end
    @(posedge clk); #1 s_arvalid = '0;
    @(negedge clk);
    checks = checks + 1;
    if (m_arvalid !== 1'b1 || m_arid !== 6'h23) begin
      failures = failures + 1;
      $display("FAIL ar_next: got valid=%b id=%h, required 1 23", m_arvalid, m_arid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks = checks + 1;
    if (ar_q.size() != 0 || m_arvalid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL ar_hold_drain: got arq=%0d valid=%b, required 0 0", ar_q.size(), m_arvalid);
    end
  endtask

  task automatic test_interleave();
    int st0;
    reset_a();
    set_ar(1, 64'h3000, 8'd1, 4'd1);
    set_ar(3, 64'h4000, 8'd1, 4'd2);
    s_arvalid = 4'b1010;
    @(posedge clk); #1 s_arvalid = 4'b1000;
    @(posedge clk); #1 s_arvalid = 4'b0000;
    @(negedge clk);
    checks = checks + 1;
    if (dut.outst_q[1] !== 2'd1 || dut.outst_q[3] !== 2'd1) begin
      failures = failures + 1;
      $display("FAIL il_issue: got outst1=%0d outst3=%0d, required 1 1", dut.outst_q[1], dut.outst_q[3]);
    end
    @(posedge clk); #1;
    st0 = stall_cnt;
    fork
      begin
        s_rready[3] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        s_rready[3] = 1'b1;
      end
      begin
        send_beat(2'd1, 4'd1, RESP_OKAY, 64'h11, 1'b0);
        send_beat(2'd3, 4'd2, RESP_OKAY, 64'h33, 1'b0);
        send_beat(2'd1, 4'd1, RESP_OKAY, 64'h12, 1'b1);
        send_beat(2'd3, 4'd2, RESP_OKAY, 64'h34, 1'b1);
      end
    join
    @(negedge clk);
    checks = checks + 1;
    if (stall_cnt - st0 != 2) begin
      failures = failures + 1;
      $display("FAIL il_stall: got %0d stalled cycles, required 2", stall_cnt - st0);
    end
    checks = checks + 1;
    if (dut.outst_q[1] !== 2'd0 || dut.outst_q[3] !== 2'd0 || r_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL il_drain: got outst1=%0d outst3=%0d rq=%0d, required 0 0 0",
               dut.outst_q[1], dut.outst_q[3], r_q.size());
    end
  endtask

  task automatic test_err_rid();
    b_rst = 1'b1; b_s_arvalid = '0; b_m_arready = 1'b0;
    b_m_rvalid = 1'b0; b_m_rid = '0; b_m_rlast = 1'b0;
    repeat (2) @(posedge clk);
    #1 b_rst = 1'b0;
    b_s_arvalid = 3'b001;
    @(posedge clk); #1 b_s_arvalid = '0;
    @(negedge clk);
    checks = checks + 1;
    if (dut_b.outst_q[0] !== 2'd1 || b_m_arvalid !== 1'b1) begin
      failures = failures + 1;
      $display("FAIL b_issue: got outst0=%0d arvalid=%b, required 1 1", dut_b.outst_q[0], b_m_arvalid);
    end
    @(posedge clk); #1;
    b_m_rvalid = 1'b1; b_m_rid = {2'd3, 4'd1}; b_m_rlast = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    if (b_m_rready !== 1'b1 || b_s_rvalid !== 3'b000 || b_err_rid !== 1'b0) begin
      failures = failures + 1;
      $display("FAIL err_beat: got rready=%b rvalid=%b err=%b, required 1 000 0", b_m_rready, b_s_rvalid, b_err_rid);
    end
    @(posedge clk); #1 b_m_rvalid = 1'b0; b_m_rlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks = checks + 1;
    if (b_err_rid !== 1'b1 || b_s_rvalid !== 3'b000 || dut_b.outst_q[0] !== 2'd1 ||
        dut_b.outst_q[1] !== 2'd0 || dut_b.outst_q[2] !== 2'd0) begin
      failures = failures + 1;
      $display("FAIL err_sticky: got err=%b rvalid=%b outst=%0d/%0d/%0d, required 1 000 1/0/0",
               b_err_rid, b_s_rvalid, dut_b.outst_q[0], dut_b.outst_q[1], dut_b.outst_q[2]);
    end
    @(posedge clk); #1;
    b_m_rvalid = 1'b1; b_m_rid = {2'd0, 4'd1};
    @(negedge clk);
    checks = checks + 1;
    if (b_s_rvalid !== 3'b001) begin
      failures = failures + 1;
      $display("FAIL b_route: got rvalid=%b, required 001", b_s_rvalid);
    end
    #2 b_rst = 1'b1;
    #1;
    checks = checks + 1;
    if (b_m_arvalid !== 1'b0 || b_err_rid !== 1'b0 || b_s_arready !== 3'b000 || dut_b.outst_q[0] !== 2'd0) begin
      failures = failures + 1;
      $display("FAIL async_reset: got arvalid=%b err=%b arready=%b outst0=%0d, required 0 0 000 0",
               b_m_arvalid, b_err_rid, b_s_arready, dut_b.outst_q[0]);
    end
    b_m_rvalid = 1'b0;
    @(posedge clk); #1 b_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    b_rst = 1'b1; b_s_arvalid = '0; b_m_arready = 1'b0;
    b_m_rvalid = 1'b0; b_m_rid = '0; b_m_rlast = 1'b0;
    test_reset();
    test_single();
    test_rr_outst();
    test_hold();
    test_interleave();
    test_err_rid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- N-to-1 AXI read-channel arbiter. Merges NUM_CH independent read masters, such as merge-tree leaf fetchers, onto one memory-side read port.
- AR requests are chosen round-robin and registered. The channel index is prepended to ARID.
- R beats are routed back to the issuing channel by the upper RID bits.
- A per-channel outstanding-burst limit prevents one channel from monopolising the memory port.

Parameters:
- NUM_CH, 4, number of upstream read channels (>=2).
- ADDR_W, 64, address width.
- DATA_W, 512, data width.
- ID_W, 4, per-channel ID width.
- MAX_OUTST, 16, maximum accepted-but-uncompleted bursts per channel (>=1).
- Derived localparams: CH_W = $clog2(NUM_CH); M_ID_W = ID_W + CH_W.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- s_arvalid  in  NUM_CH  per-channel AR valid.
- s_arready  out  NUM_CH  per-channel AR ready.
- s_araddr  in  NUM_CH*ADDR_W  packed per-channel AR address; channel i at [i*ADDR_W +: ADDR_W].
- s_arlen  in  NUM_CH*8  packed per-channel AR length.
- s_arsize  in  NUM_CH*3  packed per-channel AR size.
- s_arburst  in  NUM_CH*2  packed per-channel AR burst type.
- s_arid  in  NUM_CH*ID_W  packed per-channel AR ID.
- s_rvalid  out  NUM_CH  per-channel R valid.
- s_rready  in  NUM_CH  per-channel R ready.
- s_rdata  out  DATA_W  broadcast R data.
- s_rresp  out  2  broadcast R response.
- s_rid  out  ID_W  broadcast R ID; channel bits stripped.
- s_rlast  out  1  broadcast R last.
- m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid(M_ID_W)  out  downstream AR channel.
- m_arready  in  1  downstream AR ready.
- m_rvalid, m_rdata, m_rresp, m_rlast, m_rid(M_ID_W)  in  downstream R channel.
- m_rready  out  1  downstream R ready.
- err_rid  out  1  sticky flag: R beat carried an out-of-range channel index.

Behaviour:
- Reset values: m_arvalid=0, all s_arready=0, all outstanding counters=0, round-robin pointer=0, err_rid=0. AR payload registers are don't-care.
- Eligibility: channel i is eligible when s_arvalid[i]=1 and outst[i] < MAX_OUTST.
- Load condition: the AR output register loads when (!m_arvalid || m_arready).
- Arbitration:
  - The winner is the first eligible channel at or after rr_ptr, wrapping modulo NUM_CH.
  - s_arready[winner] = load condition; all other s_arready bits are 0.
  - On load, rr_ptr = winner+1 mod NUM_CH. rr_ptr holds when nothing loads.
- AR register: on load, capture the winner's fields and set m_arid = {winner[CH_W-1:0], s_arid[winner]}.
  - m_arvalid = 1 if any channel was eligible, else 0.
  - Latency: s_arvalid accepted in cycle t gives m_arvalid in cycle t+1.
  - Back-to-back issue is supported (one AR per cycle while m_arready=1).
- Outstanding counters (width $clog2(MAX_OUTST+1)):
  - Increment on an s-side AR handshake.
  - Decrement on an R handshake with rlast=1 routed to that channel.
  - Increment and decrement in the same cycle leaves the counter unchanged.
  - A counter never exceeds MAX_OUTST.
- R routing (combinational, zero latency):
  - ch = m_rid[M_ID_W-1 -: CH_W].
  - s_rvalid[ch] = m_rvalid; all other s_rvalid bits are 0.
  - m_rready = s_rready[ch].
  - s_rdata, s_rresp and s_rlast pass through unchanged. s_rid = m_rid[ID_W-1:0].
- Out-of-range channel (ch >= NUM_CH, possible only when NUM_CH is not a power of two):
  - m_rready=1, so the beat is dropped.
  - No s_rvalid is asserted and no counter changes.
  - err_rid is set and stays set until reset.
- Interleaving: R beats from different channels may interleave at any beat. Routing is per beat; no burst state is kept on the R path.
- AR hold: once m_arvalid=1, the payload is stable until m_arready.
- Reset mid-operation: all state clears immediately. In-flight bursts are forgotten; the downstream slave must be reset in the same domain.

Optional Feature:
- Macro AXI_RD_ARB_RSLICE_EN.
- When defined: a two-entry skid buffer is inserted on the R path.
  - Adds 1 cycle of R latency.
  - m_rready becomes a registered "buffer not full" signal, independent of s_rready.
  - Full throughput is kept; routing and err_rid detection act on the buffer output.
- When not defined: the purely combinational R path described above.

Decomposition:
- Package axi_rd_arb_pkg holds:
  - localparam function for CH_W;
  - typedef ar_req_t struct {addr, len, size, burst, id};
  - AXI response constants (OKAY=2'b00, SLVERR=2'b10).
- Sub-module rr_arbiter (NUM_REQ parameter; req vector in, one-hot grant out, advance input, rr_ptr state). Reusable elsewhere in the codebase.

Test Plan:
- Single channel: ch2 issues araddr=0x1000, arlen=3, arid=5 -> m_arvalid next cycle with m_arid={2'd2,4'd5}. The 4 returned beats appear only on s_rvalid[2] with s_rid=5; outst[2] goes 1 then 0 after rlast.
- All 4 channels assert continuously with m_arready=1 -> grant order 0,1,2,3,0,1,... with one AR per cycle.
- MAX_OUTST=2 and no R returned -> ch0 gets exactly 2 handshakes, then s_arready[0] stays 0 while ch1..3 continue. After one rlast for ch0, a third ch0 AR is accepted.
- m_arready held low for 5 cycles -> m_araddr/m_arid stable throughout and no s_arready asserted. Release -> the next winner loads in the same cycle.
- Interleaved R beats from ch1 and ch3, with s_rready[3]=0 for 3 cycles -> m_rready=0 only while a ch3 beat is at the head. No beats are lost, and outst[1] and outst[3] end at 0.
- NUM_CH=3 with m_rid channel bits=3 -> beat consumed, err_rid=1 persists, no s_rvalid, counters unchanged. Then assert rst mid-burst -> all outputs return to reset values asynchronously.
